// File: rtl/bp_me_mem_responder_lite_if.sv
// CCE memory command/response channel between a mem_cmd master and the memory-side responder.
interface bp_me_mem_responder_lite_if #(
    parameter int unsigned msg_width_p = 4 + 40 + 3 + 16 + 512
);
    logic [msg_width_p-1:0] mem_cmd_i;
    logic                   mem_cmd_v_i;
    logic                   mem_cmd_ready_o;
    logic [msg_width_p-1:0] mem_resp_o;
    logic                   mem_resp_v_o;
    logic                   mem_resp_yumi_i;

    modport master (
        output mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
        input  mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
    );

    modport slave (
        input  mem_cmd_i, mem_cmd_v_i, mem_resp_yumi_i,
        output mem_cmd_ready_o, mem_resp_o, mem_resp_v_o
    );
endinterface

// File: rtl/bp_me_mem_responder_lite.sv
// Memory-side CCE responder: block-wide array, one command in flight, fixed response latency.
module bp_me_mem_responder_lite #(
    parameter int unsigned paddr_width_p   = 40,
    parameter int unsigned payload_width_p = 16,
    parameter int unsigned block_width_p   = 512,
    parameter int unsigned mem_els_p       = 64,
    parameter int unsigned latency_p       = 4
) (
    input logic                       clk_i,
    input logic                       reset_n_i,
    bp_me_mem_responder_lite_if.slave mem_if
);
    localparam int unsigned HDR_W = 4 + paddr_width_p + 3 + payload_width_p;
    localparam int unsigned MSG_W = HDR_W + block_width_p;
    localparam int unsigned BYTES = block_width_p / 8;
    localparam int unsigned OFF_W = $clog2(BYTES);
    localparam int unsigned IDX_W = $clog2(mem_els_p);
    localparam int unsigned CNT_W = (latency_p > 1) ? $clog2(latency_p) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] T_RD    = 4'd0;
    localparam logic [3:0] T_WR    = 4'd1;
    localparam logic [3:0] T_UC_RD = 4'd2;
    localparam logic [3:0] T_UC_WR = 4'd3;
    localparam logic [3:0] T_PRE   = 4'd4;

    localparam logic [OFF_W:0]   NB_ONE  = 1;
    localparam logic [OFF_W-1:0] OFF_ONE = 1;

    logic [1:0]             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [MSG_W-1:0]       r_resp;
    logic [block_width_p-1:0] r_mem [mem_els_p];

    logic [MSG_W-1:0]         w_cmd;
    logic [3:0]               w_type;
    logic [2:0]               w_size;
    logic [2:0]               w_lg;
    logic [OFF_W-1:0]         w_off;
    logic [OFF_W-1:0]         w_boff;
    logic [OFF_W:0]           w_nbytes;
    logic [OFF_W+2:0]         w_shift;
    logic [IDX_W-1:0]         w_idx;
    logic [block_width_p-1:0] w_cmd_data;
    logic [block_width_p-1:0] w_block;
    logic [block_width_p-1:0] w_lo_mask;
    logic [block_width_p-1:0] w_uc_rd;
    logic [block_width_p-1:0] w_uc_wr_block;
    logic [block_width_p-1:0] w_wr_block;
    logic [block_width_p-1:0] w_resp_data;
    logic                     w_wr_en;
    logic                     w_accept;

    assign w_cmd      = mem_if.mem_cmd_i;
    assign w_type     = w_cmd[3:0];
    assign w_size     = w_cmd[4 + paddr_width_p +: 3];
    assign w_off      = w_cmd[4 +: OFF_W];
    assign w_idx      = w_cmd[4 + OFF_W +: IDX_W];
    assign w_cmd_data = w_cmd[HDR_W +: block_width_p];
    assign w_block    = r_mem[w_idx];

    // Uncached access width saturates at a full block; offset is aligned down to that width.
    assign w_lg     = (32'(w_size) > OFF_W) ? 3'(OFF_W) : w_size;
    assign w_nbytes = NB_ONE << w_lg;
    assign w_boff   = w_off & ~(w_nbytes[OFF_W-1:0] - OFF_ONE);
    assign w_shift  = {w_boff, 3'b000};

    always_comb begin
        w_lo_mask = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            w_lo_mask[b*8 +: 8] = (b < 32'(w_nbytes)) ? 8'hFF : 8'h00;
        end
    end

    assign w_uc_rd       = (w_block >> w_shift) & w_lo_mask;
    assign w_uc_wr_block = (w_block & ~(w_lo_mask << w_shift))
                         | ((w_cmd_data & w_lo_mask) << w_shift);

    always_comb begin
        w_wr_en     = 1'b0;
        w_wr_block  = w_block;
        w_resp_data = '0;
        case (w_type)
            T_RD:    w_resp_data = w_block;
            T_WR:    begin w_wr_en = 1'b1; w_wr_block = w_cmd_data;    end
            T_UC_RD: w_resp_data = w_uc_rd;
            T_UC_WR: begin w_wr_en = 1'b1; w_wr_block = w_uc_wr_block; end
            default: ;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && mem_if.mem_cmd_v_i && reset_n_i;

    // Array contents survive reset; only committed writes land here.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_wr_en) begin
            r_mem[w_idx] <= w_wr_block;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_resp  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && (w_type != T_PRE)) begin
                        r_resp <= {w_resp_data, w_cmd[HDR_W-1:0]};
                        if (latency_p == 1) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(latency_p - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (mem_if.mem_resp_yumi_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_if.mem_cmd_ready_o = (r_state == ST_IDLE);
    assign mem_if.mem_resp_v_o    = (r_state == ST_RESP);
    assign mem_if.mem_resp_o      = r_resp;
endmodule

// File: tb/tb_bp_me_mem_responder_lite.sv
// Scoreboard bench for bp_me_mem_responder_lite: latency-4 instance plus a latency-1 instance.
module tb_bp_me_mem_responder_lite;
    localparam int unsigned PA   = 40;
    localparam int unsigned PL   = 16;
    localparam int unsigned BW   = 512;
    localparam int unsigned HDR  = 4 + PA + 3 + PL;
    localparam int unsigned W    = HDR + BW;
    localparam int unsigned LAT0 = 4;

    typedef struct {
        logic [W-1:0] msg;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [BW-1:0] m_mem [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bp_me_mem_responder_lite_if #(.msg_width_p(W)) u_if0 ();
    bp_me_mem_responder_lite_if #(.msg_width_p(W)) u_if1 ();

    bp_me_mem_responder_lite #(
        .paddr_width_p(PA), .payload_width_p(PL), .block_width_p(BW),
        .mem_els_p(64), .latency_p(LAT0)
    ) u_dut0 (
        .clk_i(clk), .reset_n_i(reset_n), .mem_if(u_if0)
    );

    bp_me_mem_responder_lite #(
        .paddr_width_p(PA), .payload_width_p(PL), .block_width_p(BW),
        .mem_els_p(64), .latency_p(1)
    ) u_dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .mem_if(u_if1)
    );

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [3:0] ty, input logic [PA-1:0] a,
                                        input logic [2:0] sz, input logic [PL-1:0] pl,
                                        input logic [BW-1:0] d);
        return {d, pl, sz, a, ty};
    endfunction

    // Reference memory: byte-loop view of each command type.
    function automatic logic [BW-1:0] model(input logic [W-1:0] msg);
        logic [3:0]    ty;
        logic [PA-1:0] a;
        logic [2:0]    sz;
        logic [BW-1:0] d;
        logic [BW-1:0] r;
        int unsigned   idx, lg, nb, boff;
        ty = msg[3:0];
        a  = msg[4 +: PA];
        sz = msg[4 + PA +: 3];
        d  = msg[HDR +: BW];
        r  = '0;
        idx  = 32'(a[11:6]);
        lg   = (sz > 3'd6) ? 6 : 32'(sz);
        nb   = 1 << lg;
        boff = 32'(a[5:0]) & ~(nb - 1);
        case (ty)
            4'd0: r = m_mem[idx];
            4'd1: m_mem[idx] = d;
            4'd2: for (int unsigned i = 0; i < nb; i++) r[i*8 +: 8] = m_mem[idx][(boff+i)*8 +: 8];
            4'd3: for (int unsigned i = 0; i < nb; i++) m_mem[idx][(boff+i)*8 +: 8] = d[i*8 +: 8];
            default: ;
        endcase
        return r;
    endfunction

    task automatic send(input logic [W-1:0] msg, output int t_acc);
        int            n;
        exp_t          e;
        logic [BW-1:0] ed;
        n = 0;
        if (clk) @(negedge clk);
        while (!u_if0.mem_cmd_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("cmd_timeout", W'(n >= 100), W'(0));
        u_if0.mem_cmd_i   = msg;
        u_if0.mem_cmd_v_i = 1'b1;
        t_acc = cyc;
        ed = model(msg);
        if (msg[3:0] != 4'd4) begin
            e.msg = {ed, msg[HDR-1:0]};
            e.t   = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        u_if0.mem_cmd_v_i = 1'b0;
    endtask

    task automatic recv(input int hold, output logic [W-1:0] got);
        int   n;
        exp_t e;
        n = 0;
        if (clk) @(negedge clk);
        while (!u_if0.mem_resp_v_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("resp_timeout", W'(n >= 50), W'(0));
        got = u_if0.mem_resp_o;
        if (sb.size() == 0) begin
            check("sb_underflow", W'(1), W'(0));
        end else begin
            e = sb.pop_front();
            check("resp_msg", u_if0.mem_resp_o, e.msg);
            check("resp_lat", W'(cyc - e.t), W'(LAT0));
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_msg", u_if0.mem_resp_o, got);
            check("hold_v", W'(u_if0.mem_resp_v_o), W'(1));
            check("hold_rdy", W'(u_if0.mem_cmd_ready_o), W'(0));
        end
        u_if0.mem_resp_yumi_i = 1'b1;
        @(posedge clk);
        #1;
        u_if0.mem_resp_yumi_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0]  got;
        logic [W-1:0]  m;
        logic [BW-1:0] a5, pat, pat2;
        int            t0, t1, t2, t3;
        a5   = {64{8'hA5}};
        pat  = {16{32'hDEADBEEF}};
        pat2 = {8{64'h0123_4567_89AB_CDEF}};

        reset_n = 1'b1;
        u_if0.mem_cmd_i = '0; u_if0.mem_cmd_v_i = 1'b0; u_if0.mem_resp_yumi_i = 1'b0;
        u_if1.mem_cmd_i = '0; u_if1.mem_cmd_v_i = 1'b0; u_if1.mem_resp_yumi_i = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_resp_v", W'(u_if0.mem_resp_v_o), W'(0));
        check("rst_resp", u_if0.mem_resp_o, W'(0));
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", W'(u_if0.mem_cmd_ready_o), W'(1));

        // 1: full-block write then read
        send(mk(4'd1, 40'h80, 3'd6, 16'hBEEF, a5), t0);
        recv(0, got);
        send(mk(4'd0, 40'h80, 3'd6, 16'h1234, '0), t0);
        recv(0, got);
        check("t1_rd_data", W'(got[HDR +: BW]), W'(a5));

        // 2: uncached byte write and 4-byte read
        send(mk(4'd1, 40'h80, 3'd6, 16'h0001, '0), t0);
        recv(0, got);
        send(mk(4'd3, 40'h83, 3'd0, 16'h0002, BW'(8'h5C)), t0);
        recv(0, got);
        send(mk(4'd2, 40'h80, 3'd2, 16'h0003, '0), t0);
        recv(0, got);
        check("t2_ucrd_data", W'(got[HDR +: BW]), W'(32'h5C00_0000));
        send(mk(4'd0, 40'h80, 3'd6, 16'h0004, '0), t0);
        recv(0, got);
        check("t2_rd_data", W'(got[HDR +: BW]), W'(32'h5C00_0000));

        // 3: back-pressure then back-to-back
        send(mk(4'd0, 40'h80, 3'd6, 16'h0010, '0), t0);
        recv(10, got);
        @(negedge clk);
        check("t3_ready_after_yumi", W'(u_if0.mem_cmd_ready_o), W'(1));
        send(mk(4'd0, 40'h80, 3'd6, 16'h0011, '0), t1);
        recv(0, got);
        send(mk(4'd0, 40'h80, 3'd6, 16'h0012, '0), t2);
        recv(0, got);
        send(mk(4'd0, 40'h80, 3'd6, 16'h0013, '0), t3);
        recv(0, got);
        check("t3_gap_a", W'(t2 - t1), W'(5));
        check("t3_gap_b", W'(t3 - t2), W'(5));

        // 4: upper address bits alias
        send(mk(4'd1, 40'h0, 3'd6, 16'h0020, pat), t0);
        recv(0, got);
        send(mk(4'd0, 40'h1000, 3'd6, 16'h0021, '0), t0);
        recv(0, got);
        check("t4_alias_data", W'(got[HDR +: BW]), W'(pat));

        // 5: prefetch, idle yumi, unsupported type
        send(mk(4'd4, 40'h0, 3'd6, 16'h0030, '1), t0);
        u_if0.mem_resp_yumi_i = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("t5_pre_no_resp", W'(u_if0.mem_resp_v_o), W'(0));
            check("t5_pre_ready", W'(u_if0.mem_cmd_ready_o), W'(1));
        end
        u_if0.mem_resp_yumi_i = 1'b0;
        send(mk(4'd7, 40'h0, 3'd6, 16'h0031, '1), t0);
        recv(0, got);
        check("t5_t7_data", W'(got[HDR +: BW]), W'(0));
        send(mk(4'd0, 40'h0, 3'd6, 16'h0032, '0), t0);
        recv(0, got);
        check("t5_t7_no_write", W'(got[HDR +: BW]), W'(pat));

        // 6: reset during WAIT drops the pending response
        send(mk(4'd0, 40'h80, 3'd6, 16'h0040, '0), t0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("t6_rst_v", W'(u_if0.mem_resp_v_o), W'(0));
        check("t6_rst_resp", u_if0.mem_resp_o, W'(0));
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("t6_ready", W'(u_if0.mem_cmd_ready_o), W'(1));
        repeat (8) begin
            @(negedge clk);
            check("t6_no_stale", W'(u_if0.mem_resp_v_o), W'(0));
        end
        send(mk(4'd0, 40'h80, 3'd6, 16'h0041, '0), t0);
        recv(0, got);
        check("t6_retained", W'(got[HDR +: BW]), W'(32'h5C00_0000));
        check("sb_empty", W'(sb.size()), W'(0));

        // latency 1 instance
        m = mk(4'd1, 40'h40, 3'd6, 16'h0050, pat2);
        @(negedge clk);
        u_if1.mem_cmd_i = m; u_if1.mem_cmd_v_i = 1'b1; t0 = cyc;
        @(posedge clk); #1 u_if1.mem_cmd_v_i = 1'b0;
        @(negedge clk);
        check("l1_wr_v", W'(u_if1.mem_resp_v_o), W'(1));
        check("l1_wr_lat", W'(cyc - t0), W'(1));
        check("l1_wr_ready", W'(u_if1.mem_cmd_ready_o), W'(0));
        check("l1_wr_resp", u_if1.mem_resp_o, {BW'(0), m[HDR-1:0]});
        u_if1.mem_resp_yumi_i = 1'b1;
        @(posedge clk); #1 u_if1.mem_resp_yumi_i = 1'b0;
        m = mk(4'd0, 40'h40, 3'd6, 16'h0051, '0);
        @(negedge clk);
        check("l1_ready", W'(u_if1.mem_cmd_ready_o), W'(1));
        u_if1.mem_cmd_i = m; u_if1.mem_cmd_v_i = 1'b1; t0 = cyc;
        @(posedge clk); #1 u_if1.mem_cmd_v_i = 1'b0;
        @(negedge clk);
        check("l1_rd_lat", W'(cyc - t0), W'(1));
        check("l1_rd_resp", u_if1.mem_resp_o, {pat2, m[HDR-1:0]});
        u_if1.mem_resp_yumi_i = 1'b1;
        @(posedge clk); #1 u_if1.mem_resp_yumi_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
